fpm16_normalize_round: RTL and testbench



---
 rtl/fpm16_normalize_round.sv | 138 +++++++++++++
 tb/tb_fpm16_normalize_round.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fpm16_normalize_round.sv
// rtl/fpm16_normalize_round.sv - FP16 multiplier normalise/round stage, 2-deep valid/ready pipeline
// Define FPM16_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fpm16_normalize_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exp,
    input  logic [21:0] in_prod,
    input  logic [20:0] in_lod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_ovf,
    output logic        out_unf
);

    logic               s1_valid_q;
    logic               s1_sign_q;
    logic               s1_zero_q;
    logic               s1_rshift_q;
    logic [4:0]         s1_shamt_q;
    logic signed [7:0]  s1_exp_q;
    logic [21:0]        s1_prod_q;

    logic               s2_valid_q;
    logic [15:0]        s2_result_q;
    logic               s2_ovf_q;
    logic               s2_unf_q;

    logic               s1_load;
    logic               s2_load;

    logic [4:0]         shamt_d;
    logic               rshift_d;
    logic               zero_d;
    logic signed [7:0]  exp_ext;
    logic signed [7:0]  exp_d;

    logic [20:0]        aligned;
    logic [9:0]         frac;
    logic               round_up;
    logic [9:0]         frac_r;
    logic               carry;
    logic signed [7:0]  exp_r;
    logic [15:0]        result_d;
    logic               ovf_d;
    logic               unf_d;
    logic               unused_bits;

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = s1_load;

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_ovf    = s2_ovf_q;
    assign out_unf    = s2_unf_q;

    // Ascending scan so the highest set detector bit overrides lower ones.
    always_comb begin
        shamt_d = '0;
        for (int k = 0; k <= 20; k++) begin
            if (in_lod[k]) shamt_d = 5'(20 - k);
        end
        rshift_d = in_prod[21];
        zero_d   = (in_prod == 22'h0);
        exp_ext  = signed'({in_exp[6], in_exp});
        exp_d    = rshift_d ? (exp_ext + 8'sd1) : (exp_ext - signed'({3'b000, shamt_d}));
    end

    always_comb begin
        aligned = s1_rshift_q ? s1_prod_q[21:1] : (s1_prod_q[20:0] << s1_shamt_q);
        frac    = aligned[19:10];
`ifdef FPM16_RNE_EN
        // The bit shifted out by the right shift still counts toward sticky.
        round_up    = aligned[9] && ((|aligned[8:0]) || (s1_rshift_q && s1_prod_q[0]) || frac[0]);
        unused_bits = aligned[20];
`else
        round_up    = 1'b0;
        unused_bits = ^{aligned[20], aligned[9:0]};
`endif
        carry    = round_up && (&frac);
        frac_r   = frac + {9'b0, round_up};
        exp_r    = s1_exp_q + signed'({7'b0, carry});
        result_d = {s1_sign_q, exp_r[4:0], frac_r};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (s1_zero_q) begin
            result_d = {s1_sign_q, 15'h0};
        end else if (exp_r >= 8'sd31) begin
            result_d = {s1_sign_q, 5'h1F, 10'h0};
            ovf_d    = 1'b1;
        end else if (exp_r <= 8'sd0) begin
            result_d = {s1_sign_q, 15'h0};
            unf_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_rshift_q <= 1'b0;
            s1_shamt_q  <= '0;
            s1_exp_q    <= '0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 16'h0000;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q   <= in_sign;
                    s1_zero_q   <= zero_d;
                    s1_rshift_q <= rshift_d;
                    s1_shamt_q  <= shamt_d;
                    s1_exp_q    <= exp_d;
                    s1_prod_q   <= in_prod;
                end
            end
            // Output data only changes when a new beat actually moves in.
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_q <= result_d;
                    s2_ovf_q    <= ovf_d;
                    s2_unf_q    <= unf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpm16_normalize_round.sv
// tb/tb_fpm16_normalize_round.sv - directed bench for fpm16_normalize_round
module tb_fpm16_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [6:0]  in_exp = '0;
    logic [21:0] in_prod = '0;
    logic [20:0] in_lod = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_ovf;
    logic        out_unf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpm16_normalize_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_prod    (in_prod),
        .in_lod     (in_lod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic sg, input logic [6:0] ex, input logic [21:0] pr, input logic [20:0] ld);
        in_sign  = sg;
        in_exp   = ex;
        in_prod  = pr;
        in_lod   = ld;
        in_valid = 1'b1;
    endtask

    task automatic run_vec(input string tag, input logic sg, input logic [6:0] ex,
                           input logic [21:0] pr, input logic [20:0] ld,
                           input logic [15:0] res, input logic ovf, input logic unf);
        @(negedge clk);
        drive(sg, ex, pr, ld);
        chk({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_res"}, out_result, res);
        chk({tag, "_ovf"}, out_ovf, ovf);
        chk({tag, "_unf"}, out_unf, unf);
    endtask

    logic [6:0]  vx [3];
    logic [21:0] vp [3];
    logic [20:0] vl [3];
    logic        vs [3];
    logic [15:0] vr [3];
    logic [15:0] rec [4];
    logic [15:0] held;
    logic        seen;
    logic        stable;
    logic        stale;
    int          idx;
    int          got;

    initial begin
        vs[0] = 1'b0; vx[0] = 7'd15; vp[0] = 22'h100000; vl[0] = 21'h100000; vr[0] = 16'h3C00;
        vs[1] = 1'b0; vx[1] = 7'd15; vp[1] = 22'h080000; vl[1] = 21'h080000; vr[1] = 16'h3800;
        vs[2] = 1'b1; vx[2] = 7'd0;  vp[2] = 22'h100000; vl[2] = 21'h100000; vr[2] = 16'h8000;

        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 16'h0000);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_unf", out_unf, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        run_vec("one",    1'b0, 7'd15, 22'h100000, 21'h100000, 16'h3C00, 1'b0, 1'b0);
        run_vec("rsh",    1'b0, 7'd15, 22'h240000, 21'h040000, 16'h4080, 1'b0, 1'b0);
        run_vec("lsh",    1'b0, 7'd15, 22'h080000, 21'h080000, 16'h3800, 1'b0, 1'b0);
        run_vec("multi",  1'b0, 7'd15, 22'h100000, 21'h180000, 16'h3C00, 1'b0, 1'b0);
`ifdef FPM16_RNE_EN
        run_vec("round",  1'b0, 7'd15, 22'h100600, 21'h100000, 16'h3C02, 1'b0, 1'b0);
        run_vec("carry",  1'b0, 7'd15, 22'h1FFE00, 21'h100000, 16'h4000, 1'b0, 1'b0);
        run_vec("rstky",  1'b0, 7'd15, 22'h200401, 21'h000400, 16'h4001, 1'b0, 1'b0);
`else
        run_vec("round",  1'b0, 7'd15, 22'h100600, 21'h100000, 16'h3C01, 1'b0, 1'b0);
        run_vec("carry",  1'b0, 7'd15, 22'h1FFE00, 21'h100000, 16'h3FFF, 1'b0, 1'b0);
        run_vec("rstky",  1'b0, 7'd15, 22'h200401, 21'h000400, 16'h4000, 1'b0, 1'b0);
`endif
        run_vec("ovf",    1'b0, 7'd31, 22'h100000, 21'h100000, 16'h7C00, 1'b1, 1'b0);
        run_vec("emax",   1'b0, 7'd30, 22'h100000, 21'h100000, 16'h7800, 1'b0, 1'b0);
        run_vec("emin",   1'b0, 7'd1,  22'h100000, 21'h100000, 16'h0400, 1'b0, 1'b0);
        run_vec("unf",    1'b1, 7'd0,  22'h100000, 21'h100000, 16'h8000, 1'b0, 1'b1);
        run_vec("negexp", 1'b1, 7'h7F, 22'h100000, 21'h100000, 16'h8000, 1'b0, 1'b1);
        run_vec("zero",   1'b1, 7'd15, 22'h000000, 21'h000000, 16'h8000, 1'b0, 1'b0);

        // back-to-back stream with out_ready high
        idx = 0;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && got < 4) begin
                rec[got] = out_result;
                got++;
            end
            if (idx < 3) begin
                drive(vs[idx], vx[idx], vp[idx], vl[idx]);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("stream_acc", idx, 3);
        chk("stream_cnt", got, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("stream_%0d", i), rec[i], vr[i]);

        // backpressure: 3 beats offered over 5 stalled cycles
        out_ready = 1'b0;
        idx = 0;
        seen = 1'b0;
        stable = 1'b1;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (!seen) begin
                    held = out_result;
                    seen = 1'b1;
                end else if (out_result !== held) begin
                    stable = 1'b0;
                end
            end
            if (idx < 3) begin
                drive(vs[idx], vx[idx], vp[idx], vl[idx]);
                if (in_ready) idx++;
            end
        end
        chk("bp_accepted", idx, 2);
        chk("bp_ready_low", in_ready, 0);
        chk("bp_seen", seen, 1);
        chk("bp_stable", stable, 1);
        chk("bp_held", held, vr[0]);
        in_valid = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid && got < 4) begin
                rec[got] = out_result;
                got++;
            end
        end
        chk("bp_cnt", got, 2);
        chk("bp_first", rec[0], vr[0]);
        chk("bp_second", rec[1], vr[1]);

        // reset with two beats in flight
        @(negedge clk);
        drive(vs[0], vx[0], vp[0], vl[0]);
        @(negedge clk);
        drive(vs[1], vx[1], vp[1], vl[1]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", out_result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        stale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        chk("post_rst_stale", stale, 0);
        run_vec("recover", 1'b0, 7'd15, 22'h240000, 21'h040000, 16'h4080, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
